// File: rtl/punt_window_ctrl.sv
// Bus-punt and wait-state controller: claims CPU cycles that hit one of N_WIN
// address windows, interrupts the STM32 and holds the CPU until it acknowledges.
module punt_window_ctrl #(
    parameter int                      N_WIN       = 4,
    parameter int                      ADDR_W      = 24,
    parameter int                      N_IRQ       = 2,
    parameter logic [N_WIN*ADDR_W-1:0] WIN_BASE    = {24'hBFE001, 24'hDFF034, 24'hDFF016, 24'hDFF008},
    parameter logic [N_WIN*ADDR_W-1:0] WIN_MASK    = {24'hFFFF00, 24'hFFFFFE, 24'hFFFFFE, 24'hFFFFF8},
    parameter logic [N_WIN*N_IRQ-1:0]  WIN_IRQ     = 8'b01_01_01_10,
    parameter int                      PORT_SIZE   = 8,
    parameter int                      SYNC_STAGES = 2,
    parameter int                      TIMEOUT     = 4096,
    localparam int                     IDX_W       = (N_WIN > 1) ? $clog2(N_WIN) : 1
) (
    input  logic              CLKCPU_A,
    input  logic              RESET,
    input  logic              AS20,
    input  logic              DS20,
    input  logic              RW,
    input  logic [ADDR_W-1:0] A,
    input  logic [N_WIN-1:0]  WIN_EN,
    input  logic              PUNT_IN,
    output logic              PUNT_OUT,
    input  logic              MCU_ACK,
    output logic [1:0]        DSACK,
    output logic              BERR,
    output logic [N_IRQ-1:0]  IRQ,
    output logic [IDX_W-1:0]  HIT_IDX,
    output logic              BUSY,
    output logic              RW_OUT
);

    localparam int              CNT_W     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [1:0]      PORT_CODE = (PORT_SIZE == 32) ? 2'b00 :
                                            (PORT_SIZE == 16) ? 2'b01 : 2'b10;

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ACK, S_BERR, S_RECOVER} state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [SYNC_STAGES:0]   ack_sync_q, ack_sync_d;
    logic [IDX_W-1:0]       hit_idx_q, hit_idx_d;
    logic                   rw_q, rw_d;

    logic [N_WIN-1:0]       hit;
    logic [IDX_W-1:0]       hit_sel;
    logic                   any_hit;
    logic                   ack_edge;
    logic                   timeout;
    logic                   dsack_oe, berr_oe, berr_val;
    logic [1:0]             dsack_val;

    always_comb begin
        hit = '0;
        for (int i = 0; i < N_WIN; i++)
            hit[i] = WIN_EN[i] & ~AS20 & ~RESET &
                     ((A & WIN_MASK[i*ADDR_W +: ADDR_W]) ==
                      (WIN_BASE[i*ADDR_W +: ADDR_W] & WIN_MASK[i*ADDR_W +: ADDR_W]));
    end

    // Scan high to low so the lowest matching window is the one left standing.
    always_comb begin
        hit_sel = '0;
        for (int i = N_WIN - 1; i >= 0; i--)
            if (hit[i]) hit_sel = IDX_W'(i);
    end

    assign any_hit  = |hit;
    assign PUNT_OUT = (!PUNT_IN || any_hit) ? 1'b0 : 1'bz;

    // Extra history flop past the synchroniser output gives a clean edge detect.
    assign ack_sync_d = {ack_sync_q[SYNC_STAGES-1:0], MCU_ACK};
    assign ack_edge   = ack_sync_q[SYNC_STAGES-1] & ~ack_sync_q[SYNC_STAGES];
    assign timeout    = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hit_idx_d = hit_idx_q;
        rw_d      = rw_q;
        dsack_oe  = 1'b0;
        dsack_val = 2'b11;
        berr_oe   = 1'b0;
        berr_val  = 1'b1;
        IRQ       = '0;
        BUSY      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!DS20 && PUNT_IN && any_hit) begin
                    state_d   = S_WAIT;
                    hit_idx_d = hit_sel;
                    rw_d      = RW;
                    cnt_d     = '0;
                end
            end
            S_WAIT: begin
                dsack_oe = 1'b1;
                BUSY     = 1'b1;
                IRQ      = WIN_IRQ[int'(hit_idx_q)*N_IRQ +: N_IRQ];
                if (TIMEOUT != 0) cnt_d = cnt_q + CNT_W'(1);
                if (DS20)          state_d = S_IDLE;
                else if (ack_edge) state_d = S_ACK;
                else if (timeout)  state_d = S_BERR;
            end
            S_ACK: begin
                dsack_oe  = 1'b1;
                dsack_val = PORT_CODE;
                BUSY      = 1'b1;
                if (DS20) state_d = S_RECOVER;
            end
            S_BERR: begin
                dsack_oe = 1'b1;
                berr_oe  = 1'b1;
                berr_val = 1'b0;
                BUSY     = 1'b1;
                if (DS20) state_d = S_RECOVER;
            end
            S_RECOVER: begin
                // Actively drive negation for one cycle before releasing the bus.
                dsack_oe = 1'b1;
                berr_oe  = 1'b1;
                BUSY     = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign DSACK   = dsack_oe ? dsack_val : 2'bzz;
    assign BERR    = berr_oe ? berr_val : 1'bz;
    assign HIT_IDX = hit_idx_q;
    assign RW_OUT  = rw_q;

    always_ff @(posedge CLKCPU_A) begin
        if (RESET) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            ack_sync_q <= '0;
            hit_idx_q  <= '0;
            rw_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ack_sync_q <= ack_sync_d;
            hit_idx_q  <= hit_idx_d;
            rw_q       <= rw_d;
        end
    end

endmodule

// File: tb/tb_punt_window_ctrl.sv
// Directed scoreboard bench for punt_window_ctrl: default instance plus a
// TIMEOUT=8 instance sharing the same bus stimulus.
module tb_punt_window_ctrl;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, as_n, ds_n, rw, punt_in, mcu_ack;
    logic [23:0] addr;
    logic [3:0]  win_en;

    wire         punt_a, punt_b, berr_a, berr_b;
    wire  [1:0]  dsack_a, dsack_b;
    logic [1:0]  irq_a, irq_b, hit_a, hit_b;
    logic        busy_a, busy_b, rwo_a, rwo_b;

    // Released (z) lines are encoded as 8'h80 so they compare as a plain value.
    wire  [7:0]  dsack_a_o, dsack_b_o, berr_a_o, berr_b_o, punt_a_o, punt_b_o;
    assign dsack_a_o = (dsack_a === 2'bzz) ? 8'h80 : {6'd0, dsack_a};
    assign dsack_b_o = (dsack_b === 2'bzz) ? 8'h80 : {6'd0, dsack_b};
    assign berr_a_o  = (berr_a === 1'bz) ? 8'h80 : {7'd0, berr_a};
    assign berr_b_o  = (berr_b === 1'bz) ? 8'h80 : {7'd0, berr_b};
    assign punt_a_o  = (punt_a === 1'bz) ? 8'h80 : {7'd0, punt_a};
    assign punt_b_o  = (punt_b === 1'bz) ? 8'h80 : {7'd0, punt_b};

    punt_window_ctrl dut (
        .CLKCPU_A(clk), .RESET(rst), .AS20(as_n), .DS20(ds_n), .RW(rw), .A(addr),
        .WIN_EN(win_en), .PUNT_IN(punt_in), .PUNT_OUT(punt_a), .MCU_ACK(mcu_ack),
        .DSACK(dsack_a), .BERR(berr_a), .IRQ(irq_a), .HIT_IDX(hit_a), .BUSY(busy_a),
        .RW_OUT(rwo_a)
    );

    punt_window_ctrl #(.TIMEOUT(8)) dut8 (
        .CLKCPU_A(clk), .RESET(rst), .AS20(as_n), .DS20(ds_n), .RW(rw), .A(addr),
        .WIN_EN(win_en), .PUNT_IN(punt_in), .PUNT_OUT(punt_b), .MCU_ACK(mcu_ack),
        .DSACK(dsack_b), .BERR(berr_b), .IRQ(irq_b), .HIT_IDX(hit_b), .BUSY(busy_b),
        .RW_OUT(rwo_b)
    );

    string      tag_q[$];
    logic [7:0] exp_q[$];
    int         errors = 0;
    int         checks = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string t, input logic [7:0] v);
        tag_q.push_back(t);
        exp_q.push_back(v);
    endtask

    task automatic check(input logic [7:0] obs);
        string      t;
        logic [7:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=%0h", obs);
            return;
        end
        t = tag_q.pop_front();
        e = exp_q.pop_front();
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", t, obs, e);
        end
    endtask

    task automatic exp_a(input string t, input logic [7:0] ds, input logic [7:0] be,
                         input logic [7:0] irq, input logic [7:0] busy);
        push({t, "_a_dsack"}, ds);
        push({t, "_a_berr"}, be);
        push({t, "_a_irq"}, irq);
        push({t, "_a_busy"}, busy);
    endtask

    task automatic exp_b(input string t, input logic [7:0] ds, input logic [7:0] be,
                         input logic [7:0] irq, input logic [7:0] busy);
        push({t, "_b_dsack"}, ds);
        push({t, "_b_berr"}, be);
        push({t, "_b_irq"}, irq);
        push({t, "_b_busy"}, busy);
    endtask

    task automatic chk_a();
        check(dsack_a_o);
        check(berr_a_o);
        check({6'd0, irq_a});
        check({7'd0, busy_a});
    endtask

    task automatic chk_b();
        check(dsack_b_o);
        check(berr_b_o);
        check({6'd0, irq_b});
        check({7'd0, busy_b});
    endtask

    initial begin
        rst = 1'b1; as_n = 1'b1; ds_n = 1'b1; rw = 1'b1; punt_in = 1'b1;
        mcu_ack = 1'b0; addr = '0; win_en = 4'hF;

        // Reset state
        tick();
        exp_a("rst", 8'h80, 8'h80, 8'h00, 8'h00);
        push("rst_hit", 8'h00);
        push("rst_rw", 8'h00);
        tick();
        chk_a();
        check({6'd0, hit_a});
        check({7'd0, rwo_a});
        rst = 1'b0;
        tick();

        // Read DFF00A, MCU acks 10 cycles after the claim edge
        addr = 24'hDFF00A; as_n = 1'b0; ds_n = 1'b0; rw = 1'b1;
        push("s1_punt", 8'h00);
        #1 check(punt_a_o);
        exp_a("s1_claim", 8'h03, 8'h80, 8'h02, 8'h01);
        push("s1_hit", 8'h00);
        push("s1_rw", 8'h01);
        tick();
        chk_a();
        check({6'd0, hit_a});
        check({7'd0, rwo_a});
        addr = 24'h000000; win_en = 4'h0;
        for (int e = 1; e <= 12; e++) begin
            exp_a("s1_wait", 8'h03, 8'h80, 8'h02, 8'h01);
            tick();
            chk_a();
            if (e == 10) mcu_ack = 1'b1;
        end
        exp_a("s1_ack", 8'h02, 8'h80, 8'h00, 8'h01);
        push("s1_hit_held", 8'h00);
        tick();
        chk_a();
        check({6'd0, hit_a});
        ds_n = 1'b1; as_n = 1'b1; mcu_ack = 1'b0; win_en = 4'hF;
        exp_a("s1_rec", 8'h03, 8'h01, 8'h00, 8'h01);
        tick();
        chk_a();
        exp_a("s1_idle", 8'h80, 8'h80, 8'h00, 8'h00);
        exp_b("s1_idle", 8'h80, 8'h80, 8'h00, 8'h00);
        push("s1_punt_rel", 8'h80);
        tick();
        chk_a();
        chk_b();
        check(punt_a_o);

        // Disabled window, then accelerator punt without a claim
        addr = 24'hBFE001; win_en = 4'b0111; as_n = 1'b0; ds_n = 1'b0;
        push("s2_punt_z", 8'h80);
        #1 check(punt_a_o);
        exp_a("s2_noclaim", 8'h80, 8'h80, 8'h00, 8'h00);
        tick();
        chk_a();
        punt_in = 1'b0;
        push("s2_punt_acc", 8'h00);
        #1 check(punt_b_o);
        exp_a("s2_acc", 8'h80, 8'h80, 8'h00, 8'h00);
        tick();
        chk_a();
        as_n = 1'b1; ds_n = 1'b1; punt_in = 1'b1; win_en = 4'hF;
        tick();

        // Timeout on the TIMEOUT=8 instance
        addr = 24'hDFF00A; as_n = 1'b0; ds_n = 1'b0; rw = 1'b0;
        exp_b("s3_claim", 8'h03, 8'h80, 8'h02, 8'h01);
        push("s3_hit", 8'h00);
        push("s3_rw", 8'h00);
        tick();
        chk_b();
        check({6'd0, hit_b});
        check({7'd0, rwo_b});
        for (int e = 1; e <= 7; e++) begin
            exp_b("s3_wait", 8'h03, 8'h80, 8'h02, 8'h01);
            tick();
            chk_b();
        end
        exp_b("s3_berr", 8'h03, 8'h00, 8'h00, 8'h01);
        tick();
        chk_b();
        ds_n = 1'b1; as_n = 1'b1;
        exp_b("s3_rec", 8'h03, 8'h01, 8'h00, 8'h01);
        tick();
        chk_b();
        exp_b("s3_idle", 8'h80, 8'h80, 8'h00, 8'h00);
        tick();
        chk_b();

        // Ack edge lands on the timeout cycle: ack wins
        as_n = 1'b0; ds_n = 1'b0;
        tick();
        for (int e = 1; e <= 7; e++) begin
            exp_b("s4_wait", 8'h03, 8'h80, 8'h02, 8'h01);
            tick();
            chk_b();
            if (e == 5) mcu_ack = 1'b1;
        end
        exp_b("s4_ack", 8'h02, 8'h80, 8'h00, 8'h01);
        tick();
        chk_b();
        ds_n = 1'b1; as_n = 1'b1; mcu_ack = 1'b0;
        exp_b("s4_rec", 8'h03, 8'h01, 8'h00, 8'h01);
        tick();
        chk_b();
        exp_b("s4_idle", 8'h80, 8'h80, 8'h00, 8'h00);
        tick();
        chk_b();
        repeat (3) tick();

        // Abort in WAIT cycle 3; a later ack edge must be ignored
        as_n = 1'b0; ds_n = 1'b0;
        exp_a("s5_claim", 8'h03, 8'h80, 8'h02, 8'h01);
        tick();
        chk_a();
        tick();
        tick();
        ds_n = 1'b1; as_n = 1'b1;
        exp_a("s5_abort", 8'h80, 8'h80, 8'h00, 8'h00);
        tick();
        chk_a();
        mcu_ack = 1'b1;
        for (int e = 0; e < 4; e++) begin
            exp_a("s5_late_ack", 8'h80, 8'h80, 8'h00, 8'h00);
            tick();
            chk_a();
        end
        mcu_ack = 1'b0;
        repeat (4) tick();

        // Reset mid-cycle, then a fresh access to window 1
        addr = 24'hDFF034; as_n = 1'b0; ds_n = 1'b0; rw = 1'b1;
        exp_a("s6_claim", 8'h03, 8'h80, 8'h01, 8'h01);
        push("s6_hit", 8'h02);
        push("s6_rw", 8'h01);
        tick();
        chk_a();
        check({6'd0, hit_a});
        check({7'd0, rwo_a});
        tick();
        rst = 1'b1;
        exp_a("s6_reset", 8'h80, 8'h80, 8'h00, 8'h00);
        push("s6_hit_rst", 8'h00);
        push("s6_rw_rst", 8'h00);
        tick();
        chk_a();
        check({6'd0, hit_a});
        check({7'd0, rwo_a});
        rst = 1'b0; as_n = 1'b1; ds_n = 1'b1;
        tick();
        addr = 24'hDFF016; as_n = 1'b0; ds_n = 1'b0; rw = 1'b0;
        exp_a("s6_next", 8'h03, 8'h80, 8'h01, 8'h01);
        push("s6_next_hit", 8'h01);
        push("s6_next_rw", 8'h00);
        tick();
        chk_a();
        check({6'd0, hit_a});
        check({7'd0, rwo_a});
        as_n = 1'b1; ds_n = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
